// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory slice.
// Read beats travel through the return pipeline as rd_beat_t records.
package mem_resp_pkg;

  // Deepest read-return pipeline the responder supports.
  localparam int MAX_READ_LAT = 8;

  // Data field width carried by a beat; MEM_DW of the responder must not exceed it.
  localparam int MAX_DW = 64;

  // Which port a returning read belongs to.
  typedef enum logic {
    SRC_MEM  = 1'b0,
    SRC_HOST = 1'b1
  } src_t;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic              vld;
    src_t              src;
    logic [MAX_DW-1:0] data;
    logic              perr;
  } rd_beat_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth shift register of read beats for mem_responder.
// A beat entering at one edge leaves LAT edges later; flush clears every slot.
module mem_resp_pipe
  import mem_resp_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic     clk,
  input  logic     flush_i,
  input  rd_beat_t beat_i,
  output rd_beat_t beat_o
);

  rd_beat_t stage_q [LAT];

  // Shift beats one slot per cycle, or drop everything in flight on flush.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= beat_i;
      for (int i = 1; i < LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign beat_o = stage_q[LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port word SRAM responder with a fixed-latency, in-order read return.
// The initiator port has fixed priority; the host port uses idle cycles.
// Optional feature macro: MEM_PARITY_EN (per-word even parity, inject input,
// mem_rdata_perr output).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int IDX_BITS = 10,
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_write,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [MEM_DW-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvld,
  output logic [MEM_DW-1:0] host_rdata,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              addr_err
`ifdef MEM_PARITY_EN
  ,
  input  logic              perr_inject,
  output logic              mem_rdata_perr
`endif
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [MEM_DW-1:0]   mem_q [DEPTH];
`ifdef MEM_PARITY_EN
  logic                par_q [DEPTH];
`endif

  logic                acc_vld;
  logic                acc_write;
  src_t                acc_src;
  logic [MEM_AW-1:0]   acc_addr;
  logic [MEM_DW-1:0]   acc_wdata;
  logic [IDX_BITS-1:0] acc_idx;
  logic                in_range;
  logic                wr_en;
  logic [MEM_DW-1:0]   rd_word;
  logic                rd_perr;

  rd_beat_t            beat_in;
  rd_beat_t            beat_out;
  logic                mem_beat;
  logic                host_beat;

  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                addr_err_q, addr_err_d;
  logic [MEM_DW-1:0]   mem_rdata_q, mem_rdata_d;
  logic [MEM_DW-1:0]   host_rdata_q, host_rdata_d;
  logic                unused_beat;

  assign host_gnt = host_req & ~mem_req;

  // Pick the single access taken this cycle; nothing is taken while in reset.
  always_comb begin
    acc_vld   = 1'b0;
    acc_write = 1'b0;
    acc_src   = SRC_MEM;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
    if (!rst) begin
      if (mem_req) begin
        acc_vld   = 1'b1;
        acc_write = mem_write;
      end else if (host_req) begin
        acc_vld   = 1'b1;
        acc_write = host_write;
        acc_src   = SRC_HOST;
        acc_addr  = host_addr;
        acc_wdata = host_wdata;
      end
    end
  end

  assign acc_idx  = acc_addr[IDX_BITS-1:0];
  assign in_range = (acc_addr[MEM_AW-1:IDX_BITS] == '0);
  assign wr_en    = acc_vld & acc_write & in_range;
  assign rd_word  = mem_q[acc_idx];

  // Array storage is never reset so preloaded contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

`ifdef MEM_PARITY_EN
  // Store even parity of each written word, inverted when an error is injected.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_q[acc_idx] <= (^acc_wdata) ^ perr_inject;
    end
  end

  assign rd_perr = in_range & (acc_src == SRC_MEM) & ((^rd_word) ^ par_q[acc_idx]);
`else
  assign rd_perr = 1'b0;
`endif

  // Build the beat launched into the return pipeline; out-of-range reads return zero.
  always_comb begin
    beat_in      = '0;
    beat_in.vld  = acc_vld & ~acc_write;
    beat_in.src  = acc_src;
    beat_in.data = in_range ? MAX_DW'(rd_word) : '0;
    beat_in.perr = rd_perr;
  end

  mem_resp_pipe #(
    .LAT (READ_LAT)
  ) u_pipe (
    .clk     (clk),
    .flush_i (rst),
    .beat_i  (beat_in),
    .beat_o  (beat_out)
  );

  assign mem_beat  = beat_out.vld & (beat_out.src == SRC_MEM);
  assign host_beat = beat_out.vld & (beat_out.src == SRC_HOST);

  assign mem_rdata_vld = mem_beat;
  assign host_rvld     = host_beat;
  assign mem_rdata     = mem_beat  ? beat_out.data[MEM_DW-1:0] : mem_rdata_q;
  assign host_rdata    = host_beat ? beat_out.data[MEM_DW-1:0] : host_rdata_q;

`ifdef MEM_PARITY_EN
  assign mem_rdata_perr = mem_beat & beat_out.perr;
`endif

  assign unused_beat = ^{beat_out.data, beat_out.perr};

  // Next-state for saturating counters, sticky error flag and held read data.
  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    addr_err_d   = addr_err_q;
    mem_rdata_d  = mem_rdata;
    host_rdata_d = host_rdata;
    if (acc_vld && !acc_write && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (acc_vld && acc_write && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (acc_vld && !in_range) begin
      addr_err_d = 1'b1;
    end
  end

  // Register statistics and held data, clearing them on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      addr_err_q   <= 1'b0;
      mem_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      addr_err_q   <= addr_err_d;
      mem_rdata_q  <= mem_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, literal corner
// checks and a randomized run, all compared against a queue/array reference model.
module tb_mem_responder;

  localparam int MEM_AW   = 16;
  localparam int MEM_DW   = 32;
  localparam int IDX_BITS = 10;
  localparam int READ_LAT = 2;
  localparam int CNT_W    = 32;
  localparam int DEPTH    = 1 << IDX_BITS;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;
  logic              host_req;
  logic              host_write;
  logic [MEM_AW-1:0] host_addr;
  logic [MEM_DW-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvld;
  logic [MEM_DW-1:0] host_rdata;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              addr_err;
  logic              perrInject;
`ifdef MEM_PARITY_EN
  logic              mem_rdata_perr;
`endif

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_AW   (MEM_AW),
    .MEM_DW   (MEM_DW),
    .IDX_BITS (IDX_BITS),
    .READ_LAT (READ_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata_vld  (mem_rdata_vld),
    .mem_rdata      (mem_rdata),
    .host_req       (host_req),
    .host_write     (host_write),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_gnt       (host_gnt),
    .host_rvld      (host_rvld),
    .host_rdata     (host_rdata),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt),
    .addr_err       (addr_err)
`ifdef MEM_PARITY_EN
    ,
    .perr_inject    (perrInject),
    .mem_rdata_perr (mem_rdata_perr)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit checkEn  = 1'b0;

  // Reference model: word array, injected-parity flags, queue of due read returns.
  typedef struct {
    int                due;
    bit                isHost;
    logic [MEM_DW-1:0] data;
    bit                perr;
  } ret_t;

  logic [MEM_DW-1:0] modelMem [DEPTH];
  bit                modelBad [DEPTH];
  ret_t              retQ[$];
  logic [CNT_W-1:0]  expRd;
  logic [CNT_W-1:0]  expWr;
  bit                expErr;
  logic [MEM_DW-1:0] expMemData;
  logic [MEM_DW-1:0] expHostData;

  typedef struct {
    bit                rst;
    bit                mReq;
    bit                mWrite;
    logic [MEM_AW-1:0] mAddr;
    logic [MEM_DW-1:0] mData;
    bit                hReq;
    bit                hWrite;
    logic [MEM_AW-1:0] hAddr;
    logic [MEM_DW-1:0] hData;
    bit                expGnt;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare every registered output against the model for the current cycle.
  task automatic checkOutput();
    ret_t beat;
    bit   expMemVld;
    bit   expHostVld;
    bit   expPerr;
    expMemVld  = 1'b0;
    expHostVld = 1'b0;
    expPerr    = 1'b0;
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      beat = retQ.pop_front();
      if (beat.isHost) begin
        expHostVld  = 1'b1;
        expHostData = beat.data;
      end else begin
        expMemVld  = 1'b1;
        expMemData = beat.data;
        expPerr    = beat.perr;
      end
    end
    if (!checkEn) return;
    cmp("mem_rdata_vld", 64'(mem_rdata_vld), 64'(expMemVld));
    cmp("mem_rdata", 64'(mem_rdata), 64'(expMemData));
    cmp("host_rvld", 64'(host_rvld), 64'(expHostVld));
    cmp("host_rdata", 64'(host_rdata), 64'(expHostData));
    cmp("rd_cnt", 64'(rd_cnt), 64'(expRd));
    cmp("wr_cnt", 64'(wr_cnt), 64'(expWr));
    cmp("addr_err", 64'(addr_err), 64'(expErr));
`ifdef MEM_PARITY_EN
    cmp("mem_rdata_perr", 64'(mem_rdata_perr), 64'(expPerr));
`endif
  endtask

  task automatic applyStimulus(input bit r, input bit mR, input bit mW,
                               input logic [MEM_AW-1:0] mA, input logic [MEM_DW-1:0] mD,
                               input bit hR, input bit hW,
                               input logic [MEM_AW-1:0] hA, input logic [MEM_DW-1:0] hD,
                               input bit inj);
    rst        = r;
    mem_req    = mR;
    mem_write  = mW;
    mem_addr   = mA;
    mem_wdata  = mD;
    host_req   = hR;
    host_write = hW;
    host_addr  = hA;
    host_wdata = hD;
    perrInject = inj;
    #1;
  endtask

  task automatic modelAccess(input bit isHost, input bit w,
                             input logic [MEM_AW-1:0] a, input logic [MEM_DW-1:0] d);
    bit inRange;
    int idx;
    ret_t beat;
    inRange = ((a >> IDX_BITS) == 0);
    idx     = int'(a) % DEPTH;
    if (!inRange) expErr = 1'b1;
    if (w) begin
      if (expWr != '1) expWr = expWr + 1;
      if (inRange) begin
        modelMem[idx] = d;
        modelBad[idx] = perrInject;
      end
    end else begin
      if (expRd != '1) expRd = expRd + 1;
      beat.due    = cyc + READ_LAT;
      beat.isHost = isHost;
      beat.data   = inRange ? modelMem[idx] : '0;
      beat.perr   = inRange && !isHost && modelBad[idx];
      retQ.push_back(beat);
    end
  endtask

  // Apply the arbitration rule and reset semantics to the model.
  task automatic modelAccept();
    if (rst) begin
      retQ.delete();
      expRd       = '0;
      expWr       = '0;
      expErr      = 1'b0;
      expMemData  = '0;
      expHostData = '0;
    end else if (mem_req) begin
      modelAccess(1'b0, mem_write, mem_addr, mem_wdata);
    end else if (host_req) begin
      modelAccess(1'b1, host_write, host_addr, host_wdata);
    end
  endtask

  task automatic tick(input bit r, input bit mR, input bit mW,
                      input logic [MEM_AW-1:0] mA, input logic [MEM_DW-1:0] mD,
                      input bit hR, input bit hW,
                      input logic [MEM_AW-1:0] hA, input logic [MEM_DW-1:0] hD,
                      input bit inj, input bit expGnt);
    checkOutput();
    applyStimulus(r, mR, mW, mA, mD, hR, hW, hA, hD, inj);
    if (checkEn) cmp("host_gnt", 64'(host_gnt), 64'(expGnt));
    modelAccept();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  function automatic vec_t mkVec(input bit r, input bit mR, input bit mW,
                                 input logic [MEM_AW-1:0] mA, input logic [MEM_DW-1:0] mD,
                                 input bit hR, input bit hW,
                                 input logic [MEM_AW-1:0] hA, input logic [MEM_DW-1:0] hD,
                                 input bit g);
    vec_t v;
    v.rst = r; v.mReq = mR; v.mWrite = mW; v.mAddr = mA; v.mData = mD;
    v.hReq = hR; v.hWrite = hW; v.hAddr = hA; v.hData = hD; v.expGnt = g;
    return v;
  endfunction

  function automatic logic [MEM_AW-1:0] randAddr();
    logic [MEM_AW-1:0] a;
    if ($urandom_range(0, 15) == 0) a = MEM_AW'(DEPTH + $urandom_range(0, 255));
    else if ($urandom_range(0, 1) == 0) a = MEM_AW'($urandom_range(0, 31));
    else a = MEM_AW'($urandom_range(0, DEPTH - 1));
    return a;
  endfunction

  // Random traffic; a pending host request is held stable until it is granted.
  task automatic randomPhase(input int n);
    bit                hPend;
    bit                hW;
    logic [MEM_AW-1:0] hA;
    logic [MEM_DW-1:0] hD;
    bit                r;
    bit                mR;
    bit                mW;
    logic [MEM_AW-1:0] mA;
    logic [MEM_DW-1:0] mD;
    bit                inj;
    hPend = 1'b0;
    hW    = 1'b0;
    hA    = '0;
    hD    = '0;
    for (int i = 0; i < n; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      mR  = ($urandom_range(0, 99) < 55);
      mW  = ($urandom_range(0, 2) == 0);
      mA  = randAddr();
      mD  = MEM_DW'($urandom);
      inj = ($urandom_range(0, 7) == 0);
      if (!hPend && $urandom_range(0, 1) == 1) begin
        hPend = 1'b1;
        hW    = ($urandom_range(0, 2) == 0);
        hA    = randAddr();
        hD    = MEM_DW'($urandom);
      end
      tick(r, mR, mW, mA, mD, hPend, hW, hA, hD, inj, hPend & ~mR);
      if (hPend && !mR && !r) hPend = 1'b0;
    end
  endtask

  initial begin
    expRd       = '0;
    expWr       = '0;
    expErr      = 1'b0;
    expMemData  = '0;
    expHostData = '0;

    // Directed vectors covering arbitration, streaming reads, range errors and reset flush.
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 1, 1, 16'h0010, 32'hA5A5_0001, 1));
    vecs.push_back(mkVec(0, 1, 0, 16'h0010, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(1, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkVec(0, 1, 0, MEM_AW'(i), 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 0, 16'h0020, 32'h0, 1, 0, 16'h0030, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 1, 16'h0030, 32'h0BAD_F00D, 1, 0, 16'h0030, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 1, 0, 16'h0030, 32'h0, 1));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 0, 16'h0400, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 1, 16'h0400, 32'hDEAD_BEEF, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 1, 16'h0055, 32'h1234_5678, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 1, 0, 16'h0055, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(1, 1, 0, 16'h0055, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));
    vecs.push_back(mkVec(0, 0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0));

    @(negedge clk);
    tick(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    checkEn = 1'b1;
    tick(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);

    $display("[TB] preloading array through host port");
    for (int i = 0; i < DEPTH; i++)
      tick(0, 0, 0, '0, '0, 1, 1, MEM_AW'(i), MEM_DW'($urandom), 0, 1);

    $display("[TB] directed vector table");
    foreach (vecs[i])
      tick(vecs[i].rst, vecs[i].mReq, vecs[i].mWrite, vecs[i].mAddr, vecs[i].mData,
           vecs[i].hReq, vecs[i].hWrite, vecs[i].hAddr, vecs[i].hData, 0, vecs[i].expGnt);

    // Reset keeps array contents: reread words written before the reset pulse.
    tick(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    tick(0, 1, 0, 16'h0010, '0, 0, 0, '0, '0, 0, 0);
    tick(0, 1, 0, 16'h0055, '0, 0, 0, '0, '0, 0, 0);
    cmp("lit_vld_0x010", 64'(mem_rdata_vld), 64'd1);
    cmp("lit_data_0x010", 64'(mem_rdata), 64'h0000_0000_A5A5_0001);
    cmp("lit_addr_err_clr", 64'(addr_err), 64'd0);
    tick(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    cmp("lit_data_0x055", 64'(mem_rdata), 64'h0000_0000_1234_5678);
    cmp("lit_rd_cnt", 64'(rd_cnt), 64'd2);
    cmp("lit_wr_cnt", 64'(wr_cnt), 64'd0);
    idle(3);

`ifdef MEM_PARITY_EN
    $display("[TB] parity inject sequence");
    tick(0, 1, 1, 16'h0020, 32'h1, 0, 0, '0, '0, 1, 0);
    tick(0, 1, 0, 16'h0020, '0, 0, 0, '0, '0, 0, 0);
    tick(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    cmp("lit_perr_set", 64'(mem_rdata_perr), 64'd1);
    cmp("lit_perr_vld", 64'(mem_rdata_vld), 64'd1);
    tick(0, 1, 1, 16'h0020, 32'h1, 0, 0, '0, '0, 0, 0);
    tick(0, 1, 0, 16'h0020, '0, 0, 0, '0, '0, 0, 0);
    tick(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
    cmp("lit_perr_clr", 64'(mem_rdata_perr), 64'd0);
    cmp("lit_perr_clr_vld", 64'(mem_rdata_vld), 64'd1);
    idle(3);
`endif

    $display("[TB] randomized traffic");
    randomPhase(4000);
    idle(READ_LAT + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
